// File: rtl/execute_pipe.sv
// Execute stage: single-cycle ALU with a valid/ready output register,
// plus a sequential shift-add multiplier feeding the HI/LO registers.
module execute_pipe #(
    parameter int W  = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [RW-1:0] ins1,
    input  logic [RW-1:0] ins2,
    input  logic [W-1:0]  signEX,
    input  logic          regDst,
    input  logic          alusrc,
    input  logic [W-1:0]  rd1,
    input  logic [W-1:0]  rd2,
    input  logic [5:0]    aluOP,
    input  logic [W-1:0]  adderFetch,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  addres,
    output logic [W-1:0]  alures,
    output logic          aluZero,
    output logic [W-1:0]  readData2,
    output logic [RW-1:0] instruction,
    output logic          busy
);

    localparam int unsigned SW = $clog2(W);
    localparam int unsigned CW = $clog2(W + 1);
    localparam int unsigned PW = 2 * W;

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_AND   = 6'd2;
    localparam logic [5:0] OP_OR    = 6'd3;
    localparam logic [5:0] OP_XOR   = 6'd4;
    localparam logic [5:0] OP_NOR   = 6'd5;
    localparam logic [5:0] OP_SLT   = 6'd6;
    localparam logic [5:0] OP_SLTU  = 6'd7;
    localparam logic [5:0] OP_SLL   = 6'd8;
    localparam logic [5:0] OP_SRL   = 6'd9;
    localparam logic [5:0] OP_SRA   = 6'd10;
    localparam logic [5:0] OP_MULT  = 6'd16;
    localparam logic [5:0] OP_MULTU = 6'd17;
    localparam logic [5:0] OP_MFHI  = 6'd18;
    localparam logic [5:0] OP_MFLO  = 6'd19;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [W-1:0]  opb_c, alu_c, br_c, a_mag_c, b_mag_c;
    logic [SW-1:0] shamt_c;
    logic [RW-1:0] dest_c;
    logic          accept_c, is_mul_c, mul_signed_c;
    logic          start_mul, load_alu, load_mul;

    logic [W-1:0]  mcand, hi, lo, mul_addr, mul_rd2;
    logic [PW-1:0] prod, prod_fin_c;
    logic [W:0]    step_c;
    logic [CW-1:0] cnt;
    logic          mul_neg;

    assign opb_c        = alusrc ? signEX : rd2;
    assign shamt_c      = opb_c[SW-1:0];
    assign br_c         = adderFetch + (signEX << 2);
    assign dest_c       = regDst ? ins2 : ins1;
    assign in_ready     = (state == IDLE) && (!out_valid || out_ready);
    assign accept_c     = in_valid && in_ready;
    assign is_mul_c     = (aluOP == OP_MULT) || (aluOP == OP_MULTU);
    assign mul_signed_c = (aluOP == OP_MULT);
    assign a_mag_c      = (mul_signed_c && rd1[W-1])   ? (~rd1 + W'(1))   : rd1;
    assign b_mag_c      = (mul_signed_c && opb_c[W-1]) ? (~opb_c + W'(1)) : opb_c;
    assign step_c       = {1'b0, prod[PW-1:W]} + {1'b0, (prod[0] ? mcand : '0)};
    assign prod_fin_c   = mul_neg ? (~prod + PW'(1)) : prod;

    // Combinational ALU for the single-cycle operations
    always_comb begin
        alu_c = '0;
        case (aluOP)
            OP_ADD:  alu_c = rd1 + opb_c;
            OP_SUB:  alu_c = rd1 - opb_c;
            OP_AND:  alu_c = rd1 & opb_c;
            OP_OR:   alu_c = rd1 | opb_c;
            OP_XOR:  alu_c = rd1 ^ opb_c;
            OP_NOR:  alu_c = ~(rd1 | opb_c);
            OP_SLT:  alu_c = {{(W-1){1'b0}}, ($signed(rd1) < $signed(opb_c))};
            OP_SLTU: alu_c = {{(W-1){1'b0}}, (rd1 < opb_c)};
            OP_SLL:  alu_c = rd1 << shamt_c;
            OP_SRL:  alu_c = rd1 >> shamt_c;
            OP_SRA:  alu_c = $signed(rd1) >>> shamt_c;
            OP_MFHI: alu_c = hi;
            OP_MFLO: alu_c = lo;
            default: alu_c = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        start_mul = 1'b0;
        load_alu  = 1'b0;
        load_mul  = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    if (is_mul_c) begin
                        start_mul = 1'b1;
                        state_n   = MUL;
                    end else begin
                        load_alu = 1'b1;
                    end
                end
            end
            MUL: begin
                if (cnt == CW'(W - 1)) state_n = DONE;
            end
            DONE: begin
                // Wait here until the output register is free
                if (!out_valid || out_ready) begin
                    load_mul = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Shift-add multiplier on magnitudes; sign applied when the product retires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand    <= '0;
            prod     <= '0;
            mul_neg  <= 1'b0;
            cnt      <= '0;
            mul_addr <= '0;
            mul_rd2  <= '0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            if (start_mul) begin
                mcand    <= a_mag_c;
                prod     <= {{W{1'b0}}, b_mag_c};
                mul_neg  <= mul_signed_c && (rd1[W-1] ^ opb_c[W-1]);
                cnt      <= '0;
                mul_addr <= br_c;
                mul_rd2  <= rd2;
            end else if (state == MUL) begin
                prod <= {step_c, prod[W-1:1]};
                cnt  <= cnt + CW'(1);
            end
            if (load_mul) begin
                hi <= prod_fin_c[PW-1:W];
                lo <= prod_fin_c[W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            addres      <= '0;
            alures      <= '0;
            aluZero     <= 1'b1;
            readData2   <= '0;
            instruction <= '0;
        end else begin
            busy <= (state_n != IDLE);
            if (load_alu) begin
                alures      <= alu_c;
                aluZero     <= (alu_c == '0);
                addres      <= br_c;
                readData2   <= rd2;
                instruction <= dest_c;
            end else if (load_mul) begin
                alures      <= prod_fin_c[W-1:0];
                aluZero     <= (prod_fin_c[W-1:0] == '0);
                addres      <= mul_addr;
                readData2   <= mul_rd2;
                instruction <= '0;
            end
            if (load_alu || load_mul) out_valid <= 1'b1;
            else if (out_ready)       out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe: transaction-level reference model checked
// every cycle, plus hand-computed expectations for the named scenarios.
module tb_execute_pipe;

    localparam int W  = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [RW-1:0] ins1 = '0, ins2 = '0;
    logic [W-1:0]  signEX = '0;
    logic          regDst = 1'b0, alusrc = 1'b0;
    logic [W-1:0]  rd1 = '0, rd2 = '0;
    logic [5:0]    aluOP = '0;
    logic [W-1:0]  adderFetch = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  addres, alures, readData2;
    logic          aluZero;
    logic [RW-1:0] instruction;
    logic          busy;

    int checks = 0;
    int errors = 0;

    execute_pipe #(.W(W), .RW(RW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ins1(ins1), .ins2(ins2), .signEX(signEX), .regDst(regDst),
        .alusrc(alusrc), .rd1(rd1), .rd2(rd2), .aluOP(aluOP),
        .adderFetch(adderFetch), .out_valid(out_valid), .out_ready(out_ready),
        .addres(addres), .alures(alures), .aluZero(aluZero),
        .readData2(readData2), .instruction(instruction), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0]   m_alures = '0, m_addres = '0, m_rd2o = '0, m_hi = '0, m_lo = '0;
    logic [W-1:0]   p_addr = '0, p_rd2 = '0, m_b;
    logic [RW-1:0]  m_ins = '0;
    logic [2*W-1:0] m_prod = '0;
    logic           m_ov = 1'b0, m_ld, m_rdy;
    int             m_busy = 0;

    function automatic logic [W-1:0] ref_alu(input logic [5:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] h,
                                             input logic [W-1:0] l);
        int sh;
        sh = int'(b % W);
        case (op)
            6'd0:  return a + b;
            6'd1:  return a - b;
            6'd2:  return a & b;
            6'd3:  return a | b;
            6'd4:  return a ^ b;
            6'd5:  return ~(a | b);
            6'd6:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            6'd7:  return (a < b) ? W'(1) : W'(0);
            6'd8:  return a << sh;
            6'd9:  return a >> sh;
            6'd10: return W'($signed(a) >>> sh);
            6'd18: return h;
            6'd19: return l;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ov = 0; m_busy = 0; m_hi = '0; m_lo = '0; m_alures = '0;
            m_addres = '0; m_rd2o = '0; m_ins = '0;
        end else begin
            m_ld  = 1'b0;
            m_rdy = (m_busy == 0) && (!m_ov || out_ready);
            m_b   = alusrc ? signEX : rd2;
            if (m_busy == 1) begin
                if (!m_ov || out_ready) begin
                    {m_hi, m_lo} = m_prod;
                    m_alures = m_prod[W-1:0];
                    m_addres = p_addr;
                    m_rd2o   = p_rd2;
                    m_ins    = '0;
                    m_ld     = 1'b1;
                    m_busy   = 0;
                end
            end else if (m_busy > 1) begin
                m_busy--;
            end else if (in_valid && m_rdy) begin
                if (aluOP == 6'd16)
                    m_prod = {{W{rd1[W-1]}}, rd1} * {{W{m_b[W-1]}}, m_b};
                if (aluOP == 6'd17)
                    m_prod = {{W{1'b0}}, rd1} * {{W{1'b0}}, m_b};
                if (aluOP == 6'd16 || aluOP == 6'd17) begin
                    p_addr = adderFetch + (signEX << 2);
                    p_rd2  = rd2;
                    m_busy = W + 1;
                end else begin
                    m_alures = ref_alu(aluOP, rd1, m_b, m_hi, m_lo);
                    m_addres = adderFetch + (signEX << 2);
                    m_rd2o   = rd2;
                    m_ins    = regDst ? ins2 : ins1;
                    m_ld     = 1'b1;
                end
            end
            m_ov = m_ld ? 1'b1 : (out_ready ? 1'b0 : m_ov);
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready",    64'(in_ready),    64'((m_busy == 0) && (!m_ov || out_ready)));
            chk("out_valid",   64'(out_valid),   64'(m_ov));
            chk("busy",        64'(busy),        64'(m_busy != 0));
            chk("alures",      64'(alures),      64'(m_alures));
            chk("aluZero",     64'(aluZero),     64'(m_alures == '0));
            chk("addres",      64'(addres),      64'(m_addres));
            chk("readData2",   64'(readData2),   64'(m_rd2o));
            chk("instruction", 64'(instruction), 64'(m_ins));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Present one operation and hold it until accepted; returns in the next cycle
    task automatic send(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] sx, input logic src, input logic rdst,
                        input logic [RW-1:0] i1, input logic [RW-1:0] i2,
                        input logic [W-1:0] pc);
        int n;
        aluOP = op; rd1 = a; rd2 = b; signEX = sx; alusrc = src; regDst = rdst;
        ins1 = i1; ins2 = i2; adderFetch = pc; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) chk("accept_timeout", 64'(n), 64'(0));
        tick();
        in_valid = 1'b0;
    endtask

    logic [5:0] tbl_op [12] = '{6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9,
                                6'd11, 6'd12, 6'd20, 6'd63};

    initial begin
        int  cyc;
        bit  rdy_low;

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_alures",  64'(alures),    64'(0));
        chk("rst_aluZero", 64'(aluZero),   64'(1));
        chk("rst_addres",  64'(addres),    64'(0));
        chk("rst_valid",   64'(out_valid), 64'(0));
        chk("rst_busy",    64'(busy),      64'(0));
        chk("rst_ready",   64'(in_ready),  64'(1));
        tick();

        // ADD
        send(6'd0, 32'd2024, 32'd1024, 32'd1025, 1'b0, 1'b0, 5'd5, 5'd7, 32'd3024);
        @(negedge clk);
        chk("add_alures", 64'(alures),      64'(3048));
        chk("add_addres", 64'(addres),      64'(7124));
        chk("add_ins",    64'(instruction), 64'(5));
        chk("add_zero",   64'(aluZero),     64'(0));
        chk("add_rd2",    64'(readData2),   64'(1024));
        chk("add_valid",  64'(out_valid),   64'(1));
        tick();

        // SUB to zero, rd destination
        send(6'd1, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd3, 5'd10, 32'd100);
        @(negedge clk);
        chk("sub_alures", 64'(alures),      64'(0));
        chk("sub_zero",   64'(aluZero),     64'(1));
        chk("sub_ins",    64'(instruction), 64'(10));
        tick();

        // SRA with immediate shift amount
        send(6'd10, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 1'b0, 5'd1, 5'd2, 32'd0);
        @(negedge clk);
        chk("sra_alures", 64'(alures), 64'(32'hF800_0000));
        chk("sra_addres", 64'(addres), 64'(16));
        tick();

        // Logic / compare / shift / undefined codes
        for (int i = 0; i < 12; i++) begin
            send(tbl_op[i], 32'hF0F0_1234, 32'h0000_0F13, 32'hFFFF_FFFE, 1'b0, 1'b0,
                 5'(i), 5'd31, 32'h0000_0040);
            @(negedge clk);
            if (i == 0) chk("and_alures",  64'(alures), 64'(32'h0000_0210));
            if (i == 4) chk("slt_alures",  64'(alures), 64'(1));
            if (i == 5) chk("sltu_alures", 64'(alures), 64'(0));
            if (i == 9) chk("undef_zero",  64'(aluZero), 64'(1));
            tick();
        end

        // MULT -7 * 3
        send(6'd16, 32'hFFFF_FFF9, 32'd3, 32'd0, 1'b0, 1'b0, 5'd4, 5'd4, 32'd0);
        cyc = 1; rdy_low = 1'b1;
        @(negedge clk);
        while (!out_valid && cyc < 200) begin
            if (in_ready) rdy_low = 1'b0;
            cyc++;
            @(negedge clk);
        end
        chk("mult_latency", 64'(cyc),     64'(W + 2));
        chk("mult_rdy_low", 64'(rdy_low), 64'(1));
        chk("mult_lo",      64'(alures),  64'(32'hFFFF_FFEB));
        chk("mult_ins",     64'(instruction), 64'(0));
        tick();
        send(6'd18, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd2, 5'd2, 32'd0);
        @(negedge clk);
        chk("mfhi_neg", 64'(alures), 64'(32'hFFFF_FFFF));
        tick();

        // Most negative operands and unsigned extremes
        send(6'd16, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0);
        repeat (W + 2) @(negedge clk);
        tick();
        send(6'd18, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd2, 5'd2, 32'd0);
        @(negedge clk);
        chk("mfhi_minneg", 64'(alures), 64'(32'h4000_0000));
        tick();
        send(6'd16, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0);
        repeat (W + 2) @(negedge clk);
        tick();
        send(6'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0);
        repeat (W + 2) @(negedge clk);
        tick();
        send(6'd18, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd2, 5'd2, 32'd0);
        @(negedge clk);
        chk("mfhi_multu", 64'(alures), 64'(32'hFFFF_FFFE));
        tick();

        // Backpressure with two back-to-back ADDs
        out_ready = 1'b0;
        send(6'd0, 32'd10, 32'd20, 32'd0, 1'b0, 1'b0, 5'd1, 5'd2, 32'd0);
        @(negedge clk);
        chk("bp_first", 64'(alures), 64'(30));
        tick();
        aluOP = 6'd0; rd1 = 32'd5; rd2 = 32'd6; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready_low", 64'(in_ready), 64'(0));
            chk("bp_held",      64'(alures),   64'(30));
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_high", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_second", 64'(alures), 64'(11));
        tick();

        // Reset in the middle of a multiply
        send(6'd17, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0);
        repeat (9) @(negedge clk);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_alures", 64'(alures),    64'(0));
        chk("mrst_zero",   64'(aluZero),   64'(1));
        chk("mrst_valid",  64'(out_valid), 64'(0));
        chk("mrst_busy",   64'(busy),      64'(0));
        chk("mrst_ready",  64'(in_ready),  64'(1));
        tick();
        send(6'd19, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd2, 5'd2, 32'd0);
        @(negedge clk);
        chk("mrst_mflo", 64'(alures), 64'(0));
        tick();
        send(6'd18, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd2, 5'd2, 32'd0);
        @(negedge clk);
        chk("mrst_mfhi", 64'(alures), 64'(0));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        chk("watchdog", 64'(1), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_pipe.md
EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 The block SHALL have parameter W, default 32, giving the datapath width in bits (W >= 8, even).
REQ-002 The block SHALL have parameter RW, default 5, giving the register-address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream operation is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-007 The block SHALL have ports ins1 and ins2, input, RW bits each: the rt and rd destination candidates.
REQ-008 The block SHALL have port signEX, input, W bits: the sign-extended immediate.
REQ-009 The block SHALL have port regDst, input, 1 bit: 0 selects ins1 as destination, 1 selects ins2.
REQ-010 The block SHALL have port alusrc, input, 1 bit: operand B is rd2 when 0 and signEX when 1.
REQ-011 The block SHALL have ports rd1 and rd2, input, W bits each: register operands A and rd2.
REQ-012 The block SHALL have port aluOP, input, 6 bits: the operation code.
REQ-013 The block SHALL have port adderFetch, input, W bits: PC+4.
REQ-014 The block SHALL have port out_valid, output, 1 bit: the output register holds a result.
REQ-015 The block SHALL have port out_ready, input, 1 bit: downstream consumes the result.
REQ-016 The block SHALL have port addres, output, W bits: the registered branch target.
REQ-017 The block SHALL have port alures, output, W bits: the registered ALU result.
REQ-018 The block SHALL have port aluZero, output, 1 bit: registered, 1 when alures == 0.
REQ-019 The block SHALL have port readData2, output, W bits: the registered rd2 (store data).
REQ-020 The block SHALL have port instruction, output, RW bits: the registered destination register.
REQ-021 The block SHALL have port busy, output, 1 bit: high while a multiply is in progress.

Function
REQ-022 aluOP SHALL decode as: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 16 MULT (signed), 17 MULTU, 18 MFHI, 19 MFLO; any other code SHALL produce alures = 0.
REQ-023 All arithmetic SHALL be modulo 2^W; shift amount SHALL be B[log2(W)-1:0]; SLT/SLTU SHALL give 1 or 0.
REQ-024 addres SHALL equal adderFetch + (signEX << 2), truncated to W bits, for every accepted operation.
REQ-025 An operation SHALL be accepted when in_valid && in_ready.
REQ-026 in_ready SHALL equal (state == IDLE) && (!out_valid || out_ready).
REQ-027 A non-multiply operation SHALL load the output register on the cycle after acceptance (latency 1) and set out_valid.
REQ-028 out_valid SHALL clear on out_ready unless a new result loads in the same cycle; a held result SHALL stay stable while out_ready = 0.
REQ-029 The FSM SHALL have states IDLE, MUL, and DONE: IDLE goes to MUL on accepted MULT/MULTU; MUL runs a shift-add iteration of one bit per cycle for exactly W cycles, then goes to DONE; DONE writes HI/LO, loads the output register (alures = new LO, instruction = 0), and returns to IDLE.
REQ-030 MULT total latency from acceptance to out_valid SHALL be W+2 cycles; busy SHALL be high in MUL and DONE.
REQ-031 MULT SHALL multiply the magnitudes and negate the 2W-bit product when the operand signs differ; the most negative operand SHALL give the correct two's-complement result.
REQ-032 MFHI/MFLO SHALL return the HI/LO values written by the most recent completed multiply.
REQ-033 While out_valid = 1 and out_ready = 0 in DONE, the FSM SHALL hold in DONE without losing the product.

Reset
REQ-034 rst SHALL force state IDLE, out_valid = 0, busy = 0, and addres, alures, readData2, instruction, HI, and LO all to 0, with aluZero = 1.
REQ-035 rst asserted during MUL SHALL abort the multiply, leaving HI/LO at 0, and in_ready SHALL be 1 in the first cycle after release.

Verification
REQ-036 Scenario ADD: rd1=2024, rd2=1024, alusrc=0, regDst=0, ins1=5, signEX=1025, adderFetch=3024, aluOP=0 -> next cycle alures=3048, addres=7124, instruction=5, aluZero=0, readData2=1024.
REQ-037 Scenario SUB: rd1=rd2=0, regDst=1, ins2=10, aluOP=1 -> alures=0, aluZero=1, instruction=10.
REQ-038 Scenario MULT: rd1=-7, rd2=3, aluOP=16 -> in_ready=0 for 34 cycles, out_valid at cycle 34 with alures=0xFFFFFFEB; then MFHI -> 0xFFFFFFFF.
REQ-039 Scenario backpressure: out_ready=0 with two back-to-back ADDs -> the first result is held, in_ready=0, and the second is accepted only after out_ready=1.
REQ-040 Scenario reset mid-multiply: rst pulsed in cycle 10 of MULTU 0xFFFFFFFF*2 -> all outputs 0, aluZero=1, and MFLO then returns 0.
REQ-041 Scenario SRA: rd1=0x80000000, signEX=4, alusrc=1, aluOP=10 -> alures=0xF8000000.
